// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: pushbutton time-setting FSM (RUN/SET_HOUR/SET_MIN/COMMIT) with edit timeout and blink.
// Define AUTO_REPEAT_EN to let a held inc button auto-repeat once per tick after two ticks.
module clock_set_ctrl #(
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       run_en,
  output logic       load,
  output logic [3:0] load_hour,
  output logic [5:0] load_min,
  output logic [3:0] edit_hour,
  output logic [5:0] edit_min,
  output logic       blank_hour,
  output logic       blank_min,
  output logic [1:0] state
);
  localparam logic [1:0] RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, COMMIT = 2'd3;
  logic [1:0] r_state, w_next;
  logic [2:0] r_mode_s, r_inc_s;
  logic [5:0] r_to;
  logic [3:0] r_edit_hour, w_hour_inc, w_hour_ld;
  logic [5:0] r_edit_min, w_min_inc, w_min_ld;
  logic       r_phase, w_phase_n, r_run_en, r_load, r_blank_h, r_blank_m;
  logic       w_mode, w_inc_p, w_inc, w_rep, w_clr, w_in_set, w_timeout, w_enter;
  // bits [1:0] synchronize the pin, bit [2] remembers the previous level for edge detection
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_mode_s <= 3'b111;
      r_inc_s  <= 3'b111;
    end else begin
      r_mode_s <= {r_mode_s[1:0], mode_btn};
      r_inc_s  <= {r_inc_s[1:0], inc_btn};
    end
  assign w_mode    = ~r_mode_s[1] & r_mode_s[2];
  assign w_inc_p   = ~r_inc_s[1] & r_inc_s[2];
  assign w_in_set  = (r_state == SET_HOUR) || (r_state == SET_MIN);
  assign w_inc     = (w_inc_p | w_rep) & ~w_mode;
  assign w_clr     = w_mode | w_inc_p | w_rep;
  assign w_timeout = w_in_set & tick_1hz & ~w_clr & (r_to == 6'(TIMEOUT_TICKS - 1));
`ifdef AUTO_REPEAT_EN
  logic       w_inc_held;
  logic [1:0] r_hold;
  assign w_inc_held = ~r_inc_s[1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_hold <= 2'd0;
    else r_hold <= (!w_in_set || !w_inc_held) ? 2'd0 : (tick_1hz && r_hold != 2'd2) ? r_hold + 2'd1 : r_hold;
  assign w_rep = w_in_set & w_inc_held & tick_1hz & (r_hold == 2'd2);
`else
  assign w_rep = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= RUN;
    else r_state <= w_next;
  always_comb begin
    w_next = (r_state == RUN)      ? (w_mode ? SET_HOUR : RUN) :
             (r_state == SET_HOUR) ? (w_mode ? SET_MIN : w_timeout ? RUN : SET_HOUR) :
             (r_state == SET_MIN)  ? (w_mode ? COMMIT : w_timeout ? RUN : SET_MIN) : RUN;
    w_enter   = (w_next == SET_HOUR || w_next == SET_MIN) && (w_next != r_state);
    w_phase_n = w_enter ? 1'b0 : r_phase ^ tick_1hz;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_run_en  <= 1'b1;
      r_load    <= 1'b0;
      r_blank_h <= 1'b0;
      r_blank_m <= 1'b0;
    end else begin
      r_run_en  <= w_next == RUN;
      r_load    <= w_next == COMMIT;
      r_blank_h <= (w_next == SET_HOUR) & w_phase_n;
      r_blank_m <= (w_next == SET_MIN) & w_phase_n;
    end
  assign w_hour_inc = (r_edit_hour == 4'd12) ? 4'd1 : r_edit_hour + 4'd1;
  assign w_min_inc  = (r_edit_min == 6'd59) ? 6'd0 : r_edit_min + 6'd1;
  assign w_hour_ld  = (cur_hour == 4'd0 || cur_hour > 4'd12) ? 4'd12 : cur_hour;
  assign w_min_ld   = (cur_min > 6'd59) ? 6'd0 : cur_min;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_edit_hour <= 4'd12;
      r_edit_min  <= 6'd0;
      r_to        <= 6'd0;
      r_phase     <= 1'b0;
    end else begin
      r_phase <= w_phase_n;
      r_to    <= (w_in_set && !w_clr) ? r_to + {5'd0, tick_1hz} : 6'd0;
      if (r_state == RUN && w_mode) begin
        r_edit_hour <= w_hour_ld;
        r_edit_min  <= w_min_ld;
      end else if (r_state == SET_HOUR && w_inc) r_edit_hour <= w_hour_inc;
      else if (r_state == SET_MIN && w_inc) r_edit_min <= w_min_inc;
    end
  assign state      = r_state;
  assign run_en     = r_run_en;
  assign load       = r_load;
  assign blank_hour = r_blank_h;
  assign blank_min  = r_blank_m;
  assign edit_hour  = r_edit_hour;
  assign edit_min   = r_edit_min;
  assign load_hour  = r_edit_hour;
  assign load_min   = r_edit_min;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed and random stimulus for clock_set_ctrl against a behavioural model.
module tb_clock_set_ctrl;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int TO = 30;
  logic clk = 0, reset = 1, tick_1hz = 0, mode_btn = 1, inc_btn = 1;
  logic [3:0] cur_hour = 4'd5;
  logic [5:0] cur_min = 6'd42;
  logic run_en, load, blank_hour, blank_min;
  logic [3:0] load_hour, edit_hour;
  logic [5:0] load_min, edit_min;
  logic [1:0] state;
  int checks = 0, errors = 0;
  int m_state, m_hour, m_min, m_to, m_phase, m_held;

  clock_set_ctrl #(.TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_hour(cur_hour), .cur_min(cur_min), .run_en(run_en), .load(load),
    .load_hour(load_hour), .load_min(load_min), .edit_hour(edit_hour), .edit_min(edit_min),
    .blank_hour(blank_hour), .blank_min(blank_min), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":state"}, 8'(state), 8'(m_state));
    chk({tag, ":run_en"}, 8'(run_en), 8'(m_state == 0));
    chk({tag, ":load"}, 8'(load), 8'(m_state == 3));
    chk({tag, ":edit_hour"}, 8'(edit_hour), 8'(m_hour));
    chk({tag, ":edit_min"}, 8'(edit_min), 8'(m_min));
    chk({tag, ":load_hour"}, 8'(load_hour), 8'(m_hour));
    chk({tag, ":load_min"}, 8'(load_min), 8'(m_min));
    chk({tag, ":blank_hour"}, 8'(blank_hour), 8'(m_state == 1 && m_phase == 1));
    chk({tag, ":blank_min"}, 8'(blank_min), 8'(m_state == 2 && m_phase == 1));
  endtask

  task automatic model_reset();
    m_state = 0; m_hour = 12; m_min = 0; m_to = 0; m_phase = 0; m_held = 0;
  endtask

  task automatic model_mode();
    m_to = 0;
    if (m_state == 0) begin
      m_hour = (cur_hour == 0 || cur_hour > 12) ? 12 : int'(cur_hour);
      m_min  = (cur_min > 59) ? 0 : int'(cur_min);
      m_state = 1; m_phase = 0;
    end else if (m_state == 1) begin
      m_state = 2; m_phase = 0;
    end else if (m_state == 2) m_state = 3;
  endtask

  task automatic model_inc();
    m_to = 0;
    if (m_state == 1) m_hour = m_hour % 12 + 1;
    else if (m_state == 2) m_min = (m_min + 1) % 60;
  endtask

  task automatic model_tick();
    m_phase ^= 1;
    if (m_state == 1 || m_state == 2) begin
      if (inc_btn == 1'b0) m_held++;
      if (AUTO && m_held > 2) model_inc();
      else begin
        m_to++;
        if (m_to == TO) m_state = 0;
      end
    end
  endtask

  task automatic press_mode();
    mode_btn = 0;
    step(3);
    model_mode();
    check_all("mode");
    if (m_state == 3) begin
      step(1);
      m_state = 0;
      check_all("post_commit");
    end
    mode_btn = 1;
    step(3);
  endtask

  task automatic press_inc();
    inc_btn = 0;
    step(3);
    model_inc();
    check_all("inc");
    inc_btn = 1;
    m_held = 0;
    step(3);
  endtask

  task automatic do_tick();
    tick_1hz = 1;
    step(1);
    tick_1hz = 0;
    model_tick();
    check_all("tick");
  endtask

  initial begin
    int toggles;
    logic prev_b;
    bit load_seen;
    #2 reset = 0;
    model_reset();
    step(2);
    check_all("reset");
    reset = 1;
    step(2);
    press_mode();
    repeat (6) press_inc();
    chk("hour_11", 8'(edit_hour), 8'd11);
    press_inc();
    chk("hour_12", 8'(edit_hour), 8'd12);
    press_inc();
    chk("hour_wrap", 8'(edit_hour), 8'd1);
    press_mode();
    repeat (18) press_inc();
    chk("min_wrap", 8'(edit_min), 8'd0);
    press_mode();
    press_inc();
    press_mode();
    toggles = 0; prev_b = blank_hour; load_seen = 0;
    for (int i = 0; i < TO; i++) begin
      do_tick();
      if (blank_hour !== prev_b) toggles++;
      prev_b = blank_hour;
      if (load) load_seen = 1;
    end
    chk("timeout_toggles", 8'(toggles), 8'd30);
    chk("timeout_no_load", 8'(load_seen), 8'd0);
    chk("timeout_state", 8'(state), 8'd0);
    press_mode();
    mode_btn = 0; inc_btn = 0;
    step(3);
    model_mode();
    check_all("mode_inc");
    mode_btn = 1; inc_btn = 1;
    step(3);
    mode_btn = 0;
    step(3);
    chk("commit_state", 8'(state), 8'd3);
    reset = 0;
    #1;
    chk("rst_commit_load", 8'(load), 8'd0);
    chk("rst_commit_state", 8'(state), 8'd0);
    chk("rst_commit_hour", 8'(edit_hour), 8'd12);
    mode_btn = 1;
    step(3);
    reset = 1;
    model_reset();
    step(3);
    check_all("after_reset");
    cur_hour = 0; cur_min = 63;
    press_mode();
    press_mode();
    press_mode();
    cur_hour = 13; cur_min = 58;
    press_mode();
    press_mode();
    inc_btn = 0;
    step(3);
    model_inc();
    m_held = 0;
    check_all("hold_press");
    repeat (5) do_tick();
    chk("repeat_final", 8'(edit_min), AUTO ? 8'd2 : 8'd59);
    inc_btn = 1;
    m_held = 0;
    step(3);
    press_mode();
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: press_mode();
        1: press_inc();
        2: repeat ($urandom_range(1, 8)) do_tick();
        default: begin
          cur_hour = 4'($urandom_range(0, 15));
          cur_min  = 6'($urandom_range(0, 63));
        end
      endcase
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
